// File: rtl/seg7_scan_if.sv
// Display-side bundle of the 7-segment scan controller: load handshake in,
// multiplexed segment/anode drive and frame strobe out.
`timescale 1ns/1ps
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     dp_in;
  logic                  ready;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     an;
  logic                  frame_done;

  modport master (
    output load, data, dp_in,
    input  ready, seg, dp, an, frame_done
  );

  modport slave (
    input  load, data, dp_in,
    output ready, seg, dp, an, frame_done
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed 7-segment scanner with per-slot blanking and a shadow
// register that is committed only at frame boundaries.
//   state    | meaning
//   ST_OFF   | scan disabled or just reset, display blank
//   ST_BLANK | leading blank cycles of a slot, all anodes off
//   ST_SHOW  | current digit's anode on
`timescale 1ns/1ps
module seg7_scan_controller #(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 10000,
  parameter int BLANK_CYC = 400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  seg7_scan_if.slave   bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic [1:0] {ST_OFF, ST_BLANK, ST_SHOW} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] active_q, shadow_q;
  logic [DIGITS-1:0]   active_dp_q, shadow_dp_q;
  logic                ready_q;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fd_q, fd_d;
  logic [3:0]          nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  // cnt_q/idx_q name the slot position that the next edge will display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  always_comb begin
    state_d = ST_OFF;
    if (en_i) state_d = (cnt_q < CNT_BLANK) ? ST_BLANK : ST_SHOW;
  end

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    nib   = active_q[{idx_q, 2'b00} +: 4];
    if (state_d == ST_SHOW) begin
      an_d[idx_q] = 1'b0;
      seg_d       = decode(nib);
      dp_d        = ~active_dp_q[idx_q];
    end
    // ST_OFF in state_q marks the first enabled edge, which is not a frame end
    fd_d = en_i && (state_q != ST_OFF) && (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      active_q    <= '0;
      active_dp_q <= '0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      if (!en_i) begin
        cnt_q <= '0;
        idx_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (fd_q && !ready_q) begin
        active_q    <= shadow_q;
        active_dp_q <= shadow_dp_q;
        ready_q     <= 1'b1;
      end else if (bus.load && ready_q) begin
        shadow_q    <= bus.data;
        shadow_dp_q <= bus.dp_in;
        ready_q     <= 1'b0;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;
  assign bus.ready      = ready_q;
endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
Time-multiplexing scheduler that shares one 7-segment cathode bus (SEG/DP) among DIGITS common-anode digits on the 40 MHz system clock. It contains its own prescaler, so it replaces the free-running divider as the scan-timing source. It inserts a blanking gap between digits to stop ghosting. A LOAD/READY handshake accepts new display values into a shadow register, which is committed only at a frame boundary so the display never tears.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
TICK_DIV, 10000, clock cycles per digit slot (4 kHz slot at 40 MHz); must be >= 2
BLANK_CYC, 400, leading cycles of each slot with all anodes off; 0 < BLANK_CYC < TICK_DIV

Ports:
CLK  in  1  system clock, 40 MHz
RST  in  1  asynchronous, active-high reset
EN  in  1  scan enable; 0 blanks the display and holds the scheduler in its reset position
LOAD  in  1  request to capture DATA_IN/DP_IN; accepted only when READY=1
DATA_IN  in  4*DIGITS  hex nibble per digit; digit i = DATA_IN[4i+3:4i]
DP_IN  in  DIGITS  decimal point per digit, 1 = lit
READY  out  1  1 = shadow register empty, LOAD will be accepted
SEG  out  7  active-low segments {g,f,e,d,c,b,a}
DP  out  1  active-low decimal point
AN  out  DIGITS  active-low anode enables, one-hot-low or all-high
FRAME_DONE  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (async, RST=1):
  - AN all 1, SEG=7'h7F, DP=1, FRAME_DONE=0, READY=1.
  - Slot counter=0, digit index=0, active and shadow registers=0.
- State per slot: BLANK for cycles 0..BLANK_CYC-1 of the slot, then SHOW for cycles BLANK_CYC..TICK_DIV-1.
- All outputs are registered.
- Timing reference: let k=0 be the first rising edge with RST=0 and EN=1, and s=floor(k/TICK_DIV).
  - During BLANK: AN all 1, SEG=7'h7F, DP=1.
  - During SHOW: AN bit (s mod DIGITS)=0 and all other bits 1; SEG=decode(active nibble of that digit); DP=~active_dp of that digit.
- Decode table (hex, active-low gfedcba): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Slot end (counter=TICK_DIV-1): counter wraps to 0 and the index increments. When the index is DIGITS-1 it wraps to 0.
- Frame end (index wraps DIGITS-1 to 0):
  - FRAME_DONE=1 on the cycle after the final SHOW cycle, coincident with the first BLANK cycle of digit 0.
  - In that same cycle, if READY=0: active<=shadow and READY<=1.
- Handshake:
  - LOAD with READY=1 captures DATA_IN/DP_IN into shadow; READY=0 from the next cycle.
  - LOAD with READY=0 is ignored; the shadow register is unchanged.
  - If LOAD arrives in the commit cycle, the commit uses the old shadow and the LOAD is dropped, because READY was 0.
  - If READY=1 at the frame wrap, a LOAD in that cycle is captured and commits at the following frame end.
- EN=0 (synchronous):
  - Next cycle: counter=0, index=0, outputs blank, FRAME_DONE=0.
  - Shadow, active and READY are retained; the LOAD handshake still operates.
  - On EN rising, scanning restarts at k=0, i.e. a full BLANK on digit 0.
- The digit never changes while its anode is on: AN is always 1 for at least BLANK_CYC cycles between any two anode-low windows.
- RST mid-frame forces the reset state immediately; pending shadow data is discarded.

Test Plan:
Overrides for all scenarios: DIGITS=4, TICK_DIV=8, BLANK_CYC=2, CLK period 25 ns.
- Reset and first frame: RST pulse, EN=1, no LOAD -> AN=F for k=0..1, AN=E with SEG=40 for k=2..7, AN=D at k=10..15, and so on; FRAME_DONE=1 exactly at k=32; no overlap between anode windows.
- Load and commit: at k=5, LOAD with DATA_IN=16'hA1B8, DP_IN=4'b0010 -> READY=0 at k=6; digits still show 0 until k=32; from the next frame, digit0 SEG=00 (8), digit1 SEG=03 with DP=0, digit2 SEG=79, digit3 SEG=08; READY=1 at k=33.
- Back-to-back LOAD: two LOADs at k=5 and k=10 with different data -> only the first is committed; the second is ignored.
- LOAD in the commit cycle: LOAD at k=32 with READY=0 -> dropped; LOAD at k=32 with READY=1 -> captured, commits at k=64.
- EN toggle: EN=0 at k=13 for 5 cycles -> AN=F and FRAME_DONE=0 throughout; on re-enable, digit 0 blanks for 2 cycles then shows; the committed data is unchanged.
- Async reset mid-SHOW: RST asserted between clock edges during AN=B -> AN=F, SEG=7F and READY=1 immediately, without waiting for an edge.
